// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - UART byte stream to IMEM word writes, halt append, core release
//
// Frame: 4-byte little-endian length N, then N payload bytes packed into
// little-endian 32-bit words. Once the payload is written, a 0xFFFF_FFFF halt
// word is appended and start is raised to release the fetch stage.
//
// Ports:
//   clk                 in   1   clock
//   rst                 in   1   synchronous, active-high reset
//   rx_data             in   8   byte from UART receiver
//   rx_valid            in   1   1-clk strobe, rx_data valid
//   reload              in   1   1-clk strobe: drop start, await new frame
//   write_byte_address  out  32  IMEM byte address, always word aligned
//   write_instr_data    out  32  IMEM write word
//   write_instr_valid   out  1   1-clk IMEM write strobe
//   start               out  1   1 = program loaded, core runs
//   load_error          out  1   sticky error flag

module instruction_loader #(
    parameter int MAX_BYTES      = 4096,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        reload,
    output logic [31:0] write_byte_address,
    output logic [31:0] write_instr_data,
    output logic        write_instr_valid,
    output logic        start,
    output logic        load_error
);

    localparam int          WIDX_W    = $clog2(MAX_BYTES / 4);
    localparam logic [31:0] LEN_LIMIT = 32'(MAX_BYTES - 4);
    localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_PAD,
        S_HALT,
        S_RUN,
        S_ERR
    } state_t;

    state_t             state, state_n;
    logic [31:0]        len, len_n;
    logic [31:0]        byte_cnt, byte_cnt_n;
    logic [WIDX_W-1:0]  word_idx, word_idx_n;
    logic [31:0]        word_buf, word_buf_n;
    logic [31:0]        idle_cnt, idle_cnt_n;

    logic [31:0]        wr_addr_n;
    logic [31:0]        wr_data_n;
    logic               wr_valid_n;
    logic               start_n;
    logic               load_error_n;

    logic [31:0]        cur_addr;
    logic [31:0]        merged;
    logic [31:0]        len_shift;

    assign cur_addr  = {{(30 - WIDX_W){1'b0}}, word_idx, 2'b00};
    // Length bytes shift in from the top so byte0 lands in [7:0] after four.
    assign len_shift = {rx_data, len[31:8]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_LEN;
            len                <= '0;
            byte_cnt           <= '0;
            word_idx           <= '0;
            word_buf           <= '1;
            idle_cnt           <= '0;
            write_byte_address <= '0;
            write_instr_data   <= '0;
            write_instr_valid  <= 1'b0;
            start              <= 1'b0;
            load_error         <= 1'b0;
        end else begin
            state              <= state_n;
            len                <= len_n;
            byte_cnt           <= byte_cnt_n;
            word_idx           <= word_idx_n;
            word_buf           <= word_buf_n;
            idle_cnt           <= idle_cnt_n;
            write_byte_address <= wr_addr_n;
            write_instr_data   <= wr_data_n;
            write_instr_valid  <= wr_valid_n;
            start              <= start_n;
            load_error         <= load_error_n;
        end
    end

    always_comb begin
        state_n    = state;
        len_n      = len;
        byte_cnt_n = byte_cnt;
        word_idx_n = word_idx;
        word_buf_n = word_buf;
        idle_cnt_n = idle_cnt;
        wr_addr_n  = write_byte_address;
        wr_data_n  = write_instr_data;
        wr_valid_n = 1'b0;
        merged     = word_buf;

        if (reload) begin
            // Any byte or write coinciding with reload is dropped.
            state_n    = S_LEN;
            len_n      = '0;
            byte_cnt_n = '0;
            word_idx_n = '0;
            word_buf_n = '1;
            idle_cnt_n = '0;
        end else begin
            case (state)
                S_LEN: begin
                    if (rx_valid) begin
                        len_n      = len_shift;
                        idle_cnt_n = '0;
                        if (byte_cnt == 32'd3) begin
                            byte_cnt_n = '0;
                            if (len_shift > LEN_LIMIT)
                                state_n = S_ERR;
                            else if (len_shift == 32'd0)
                                state_n = S_HALT;
                            else
                                state_n = S_DATA;
                        end else begin
                            byte_cnt_n = byte_cnt + 32'd1;
                        end
                    end else if (byte_cnt != 32'd0) begin
                        if (idle_cnt == IDLE_LAST)
                            state_n = S_ERR;
                        else
                            idle_cnt_n = idle_cnt + 32'd1;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        idle_cnt_n = '0;
                        merged[{byte_cnt[1:0], 3'b000} +: 8] = rx_data;
                        word_buf_n = merged;
                        byte_cnt_n = byte_cnt + 32'd1;
                        if (byte_cnt[1:0] == 2'd3) begin
                            wr_valid_n = 1'b1;
                            wr_data_n  = merged;
                            wr_addr_n  = cur_addr;
                            word_idx_n = word_idx + WIDX_W'(1);
                            // Unfilled lanes default to 0xFF for the pad word.
                            word_buf_n = '1;
                        end
                        if (byte_cnt == len - 32'd1)
                            state_n = (byte_cnt[1:0] == 2'd3) ? S_HALT : S_PAD;
                    end else begin
                        if (idle_cnt == IDLE_LAST)
                            state_n = S_ERR;
                        else
                            idle_cnt_n = idle_cnt + 32'd1;
                    end
                end
                S_PAD: begin
                    wr_valid_n = 1'b1;
                    wr_data_n  = word_buf;
                    wr_addr_n  = cur_addr;
                    word_idx_n = word_idx + WIDX_W'(1);
                    word_buf_n = '1;
                    state_n    = S_HALT;
                end
                S_HALT: begin
                    // Opcode 7'b1111111 stalls the fetch stage.
                    wr_valid_n = 1'b1;
                    wr_data_n  = 32'hFFFF_FFFF;
                    wr_addr_n  = cur_addr;
                    state_n    = S_RUN;
                end
                S_RUN: begin
                    state_n = S_RUN;
                end
                S_ERR: begin
                    state_n = S_ERR;
                end
                default: begin
                    state_n = S_ERR;
                end
            endcase
        end

        // start trails the halt write by one clk, so it never overlaps a write.
        start_n      = (state == S_RUN) && (state_n == S_RUN);
        load_error_n = (state_n == S_ERR);
    end

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - directed self-checking bench for instruction_loader

module tb_instruction_loader;

    localparam int TO = 20;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        reload;
    logic [31:0] write_byte_address;
    logic [31:0] write_instr_data;
    logic        write_instr_valid;
    logic        start;
    logic        load_error;

    int n_checks;
    int n_fail;
    int n_viol;

    logic [31:0] wa[$];
    logic [31:0] wd[$];

    instruction_loader #(
        .MAX_BYTES     (4096),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .reload            (reload),
        .write_byte_address(write_byte_address),
        .write_instr_data  (write_instr_data),
        .write_instr_valid (write_instr_valid),
        .start             (start),
        .load_error        (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (write_instr_valid) begin
            wa.push_back(write_byte_address);
            wd.push_back(write_instr_data);
            if (start) n_viol++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_len(input logic [31:0] n);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        send_byte(n[23:16]);
        send_byte(n[31:24]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
    endtask

    task automatic check_frame1(input string tag);
        chk({tag, "_nwr"}, 32'(wa.size()), 32'd3);
        if (wa.size() == 3) begin
            chk({tag, "_a0"}, wa[0], 32'h0);
            chk({tag, "_d0"}, wd[0], 32'h0000_0513);
            chk({tag, "_a1"}, wa[1], 32'h4);
            chk({tag, "_d1"}, wd[1], 32'h0010_0593);
            chk({tag, "_a2"}, wa[2], 32'h8);
            chk({tag, "_d2"}, wd[2], 32'hFFFF_FFFF);
        end
        chk({tag, "_start"}, 32'(start), 32'd1);
        chk({tag, "_err"}, 32'(load_error), 32'd0);
    endtask

    task automatic send_frame1();
        send_len(32'd8);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_viol   = 0;
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        reload   = 1'b0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_valid", 32'(write_instr_valid), 32'd0);
        chk("rst_addr", write_byte_address, 32'd0);
        chk("rst_data", write_instr_data, 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_err", 32'(load_error), 32'd0);
        idle(30);
        chk("idle_no_timeout", 32'(load_error), 32'd0);

        // 1: two full words
        clear_log();
        send_frame1();
        idle(5);
        check_frame1("t1");

        // 3: empty program, reload coinciding with a byte drops the byte
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        reload   = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        reload   = 1'b0;
        chk("t3_reload_start", 32'(start), 32'd0);
        clear_log();
        send_len(32'd0);
        @(negedge clk);
        chk("t3_valid", 32'(write_instr_valid), 32'd1);
        chk("t3_addr", write_byte_address, 32'd0);
        chk("t3_data", write_instr_data, 32'hFFFF_FFFF);
        chk("t3_start_pre", 32'(start), 32'd0);
        @(negedge clk);
        chk("t3_start", 32'(start), 32'd1);
        chk("t3_valid_off", 32'(write_instr_valid), 32'd0);
        idle(3);
        chk("t3_nwr", 32'(wa.size()), 32'd1);

        // 4: oversize length rejected, boundary length accepted
        pulse_reload();
        clear_log();
        send_len(32'h0000_1000);
        idle(3);
        chk("t4_err", 32'(load_error), 32'd1);
        chk("t4_start", 32'(start), 32'd0);
        send_byte(8'h11);
        idle(3);
        chk("t4_nwr", 32'(wa.size()), 32'd0);
        pulse_reload();
        chk("t4_err_clr", 32'(load_error), 32'd0);
        send_len(32'h0000_0FFD);
        idle(2);
        chk("t4_err_ffd", 32'(load_error), 32'd1);
        pulse_reload();
        send_len(32'h0000_0FFC);
        idle(2);
        chk("t4_ok_ffc", 32'(load_error), 32'd0);
        chk("t4_ffc_nwr", 32'(wa.size()), 32'd0);

        // 2: partial word padded with 0xFF
        pulse_reload();
        clear_log();
        send_len(32'd6);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h45);
        idle(5);
        chk("t2_nwr", 32'(wa.size()), 32'd3);
        if (wa.size() == 3) begin
            chk("t2_a0", wa[0], 32'h0);
            chk("t2_d0", wd[0], 32'h0000_0513);
            chk("t2_a1", wa[1], 32'h4);
            chk("t2_d1", wd[1], 32'hFFFF_4501);
            chk("t2_a2", wa[2], 32'h8);
            chk("t2_d2", wd[2], 32'hFFFF_FFFF);
        end
        chk("t2_start", 32'(start), 32'd1);

        // 5: idle timeout mid-payload, with a keep-alive byte at the last moment
        pulse_reload();
        clear_log();
        send_len(32'd8);
        send_byte(8'h13);
        send_byte(8'h05);
        idle(TO - 1);
        chk("t5_alive", 32'(load_error), 32'd0);
        send_byte(8'h00);
        idle(TO - 1);
        chk("t5_alive2", 32'(load_error), 32'd0);
        @(negedge clk);
        chk("t5_timeout", 32'(load_error), 32'd1);
        chk("t5_start", 32'(start), 32'd0);
        chk("t5_nwr", 32'(wa.size()), 32'd0);

        // 6: reload while running, new frame overwrites from @0, then rst mid-frame
        pulse_reload();
        clear_log();
        send_frame1();
        idle(5);
        check_frame1("t6a");
        pulse_reload();
        chk("t6_reload_start", 32'(start), 32'd0);
        clear_log();
        send_len(32'd4);
        send_byte(8'h37); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        idle(5);
        chk("t6_nwr", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            chk("t6_a0", wa[0], 32'h0);
            chk("t6_d0", wd[0], 32'h0000_0137);
            chk("t6_a1", wa[1], 32'h4);
            chk("t6_d1", wd[1], 32'hFFFF_FFFF);
        end
        chk("t6_start", 32'(start), 32'd1);
        pulse_reload();
        send_len(32'd8);
        send_byte(8'h13);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_addr", write_byte_address, 32'd0);
        chk("t6_rst_data", write_instr_data, 32'd0);
        chk("t6_rst_valid", 32'(write_instr_valid), 32'd0);
        chk("t6_rst_start", 32'(start), 32'd0);
        chk("t6_rst_err", 32'(load_error), 32'd0);
        clear_log();
        send_len(32'd0);
        idle(4);
        chk("t6_post_nwr", 32'(wa.size()), 32'd1);
        chk("t6_post_start", 32'(start), 32'd1);

        chk("no_write_while_start", 32'(n_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
